// File: rtl/ram_stream_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ram_stream_reader_if
// Brief    : RAM read port plus valid/ready output stream of the RAM reader.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) ();
  logic [ADDR_WIDTH-1:0] oReadAddress;
  logic                  oReadValid;
  logic [DATA_WIDTH-1:0] iRamData;
  logic [DATA_WIDTH-1:0] oData;
  logic                  oValid;
  logic                  iReady;

  // master = the reader; slave = the RAM/sink side it talks to
  modport master (
    output oReadAddress, oReadValid, oData, oValid,
    input  iRamData, iReady
  );
  modport slave (
    input  oReadAddress, oReadValid, oData, oValid,
    output iRamData, iReady
  );
endinterface
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ram_stream_reader
// Brief    : Burst reader for a 1-cycle-latency RAM, streaming words out
//            through a 2-entry buffer with credit-based read issue.
// Revision : 1.0 - initial release
// ============================================================================
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStart,
  input  logic [ADDR_WIDTH-1:0] iBaseAddr,
  input  logic [ADDR_WIDTH:0]   iCount,
  output logic                  oBusy,
  output logic                  oDone,
  ram_stream_reader_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] c_CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_done_next;

  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_issued;
  logic [ADDR_WIDTH:0]   r_beats;
  logic                  r_inflight;
  logic [1:0]            r_occ;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic                  r_done;

  logic                  w_start;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic [ADDR_WIDTH:0]   w_issued_next;
  logic [ADDR_WIDTH:0]   w_beats_next;

  assign w_start       = (r_state == S_IDLE) && iStart;
  assign w_pop         = (r_occ != 2'd0) && bus.iReady;
  assign w_push        = r_inflight;
  assign w_issued_next = r_issued + c_CNT_ONE;
  assign w_beats_next  = r_beats + {{ADDR_WIDTH{1'b0}}, w_pop};
  assign w_issue_addr  = r_base + r_issued[ADDR_WIDTH-1:0];

  // A read is a credit on a buffer slot: words held plus the one in flight,
  // minus the one leaving this cycle, must leave room for the new response.
  assign w_issue = (r_state == S_RUN) && (r_issued < r_count) &&
                   (({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          if (iCount == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_issue && (w_issued_next == r_count)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && (w_beats_next == r_count)) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_base      <= '0;
      r_count     <= '0;
      r_issued    <= '0;
      r_beats     <= '0;
      r_last_addr <= '0;
    end else if (w_start) begin
      r_base   <= iBaseAddr;
      r_count  <= iCount;
      r_issued <= '0;
      r_beats  <= '0;
    end else begin
      if (w_issue) begin
        r_issued    <= w_issued_next;
        r_last_addr <= w_issue_addr;
      end
      if (w_pop) begin
        r_beats <= w_beats_next;
      end
    end
  end

  // Clearing the in-flight flag on reset drops a response still in the RAM pipe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= w_issue;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_head <= bus.iRamData;
            r_occ  <= 2'd1;
          end else begin
            r_tail <= bus.iRamData;
            r_occ  <= 2'd2;
          end
        end
        2'b01: begin
          if (r_occ == 2'd2) begin
            r_head <= r_tail;
          end
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= bus.iRamData;
          end else begin
            r_head <= r_tail;
            r_tail <= bus.iRamData;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.oReadValid   = w_issue;
  assign bus.oReadAddress = w_issue ? w_issue_addr : r_last_addr;
  assign bus.oValid       = (r_occ != 2'd0);
  assign bus.oData        = r_head;
  assign oBusy            = (r_state != S_IDLE);
  assign oDone            = r_done;

  a_no_overflow : assert property (@(posedge Clock) disable iff (Reset)
    !(w_push && !w_pop && (r_occ == 2'd2)));
  a_occ_range : assert property (@(posedge Clock) disable iff (Reset)
    (r_occ != 2'd3));

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ram_stream_reader
// Brief    : Directed self-checking bench for ram_stream_reader with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_stream_reader;

  logic       Clock;
  logic       Reset;
  logic       iStart;
  logic [9:0] iBaseAddr;
  logic [10:0] iCount;
  logic       iReady;
  logic       oBusy;
  logic       oDone;
  logic [7:0] ram_q;
  logic [7:0] mem [0:1023];

  int n_vec = 0;
  int n_err = 0;

  // hand-derived cycle table for base=0x010, count=4, sink always ready
  int exp_rv   [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
  int exp_addr [9] = '{'h000, 'h010, 'h011, 'h012, 'h013, 'h013, 'h013, 'h013, 'h013};
  int exp_ov   [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
  int exp_d    [9] = '{'h00, 'h00, 'h00, 'h10, 'h11, 'h12, 'h13, 'h13, 'h13};
  int exp_busy [9] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
  int exp_done [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

  ram_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus ();

  ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iStart    (iStart),
    .iBaseAddr (iBaseAddr),
    .iCount    (iCount),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .bus       (bus)
  );

  assign bus.iReady   = iReady;
  assign bus.iRamData = ram_q;

  always @(posedge Clock) ram_q <= mem[bus.oReadAddress];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a burst at cycle 0 and steps until two cycles past oDone.
  // mode 0: ready always; 1: ready low on cycles 3..8; 2: random ready.
  task automatic run_burst(input logic [9:0] base, input logic [10:0] count,
                           input int mode, input int restart_cyc, input bit use_table,
                           output int done_cyc, output int beats, output int reads,
                           output int dones, output int valid_seen);
    int k_issue;
    int cyc;
    logic [9:0] ea;
    logic [7:0] prev_data;
    logic prev_stall;
    done_cyc = -1; beats = 0; reads = 0; dones = 0; valid_seen = 0;
    k_issue = 0; prev_stall = 1'b0; prev_data = '0;
    iBaseAddr = base;
    iCount    = count;
    cyc = 0;
    while (cyc < 6000) begin
      iStart = (cyc == 0) || (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        iBaseAddr = 10'h155;
        iCount    = 11'd5;
      end
      case (mode)
        1:       iReady = !(cyc >= 3 && cyc <= 8);
        2:       iReady = 1'($urandom_range(0, 1));
        default: iReady = 1'b1;
      endcase
      @(negedge Clock);
      if (use_table && cyc < 9) begin
        check_val("tbl_rv",   bus.oReadValid,   exp_rv[cyc]);
        check_val("tbl_addr", bus.oReadAddress, exp_addr[cyc]);
        check_val("tbl_ov",   bus.oValid,       exp_ov[cyc]);
        check_val("tbl_data", bus.oData,        exp_d[cyc]);
        check_val("tbl_busy", oBusy,            exp_busy[cyc]);
        check_val("tbl_done", oDone,            exp_done[cyc]);
      end
      if (mode == 1 && cyc >= 3 && cyc <= 8) begin
        check_val("stall_rv",   bus.oReadValid, 0);
        check_val("stall_data", bus.oData,      8'h10);
      end
      if (bus.oReadValid) begin
        ea = base + k_issue[9:0];
        check_val("raddr", bus.oReadAddress, ea);
        k_issue++;
        reads++;
      end
      if (prev_stall) check_val("hold", bus.oData, prev_data);
      if (bus.oValid) valid_seen++;
      if (bus.oValid && iReady) begin
        ea = base + beats[9:0];
        check_val("beat", bus.oData, ea[7:0]);
        beats++;
      end
      prev_stall = bus.oValid && !iReady;
      prev_data  = bus.oData;
      if (oDone) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge Clock); #1;
      cyc++;
      if (done_cyc >= 0 && cyc > done_cyc + 2) break;
    end
    iStart = 1'b0;
  endtask

  int d_cyc, n_beats, n_reads, n_dones, n_valid;
  int idle_bad;

  initial begin
    Reset = 1'b1; iStart = 1'b0; iBaseAddr = '0; iCount = '0; iReady = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = i[7:0];

    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_val("rst_rv",   bus.oReadValid,   0);
    check_val("rst_addr", bus.oReadAddress, 0);
    check_val("rst_data", bus.oData,        0);
    check_val("rst_ov",   bus.oValid,       0);
    check_val("rst_busy", oBusy,            0);
    check_val("rst_done", oDone,            0);
    @(posedge Clock); #1;
    Reset = 1'b0;

    run_burst(10'h010, 11'd4, 0, -1, 1'b1, d_cyc, n_beats, n_reads, n_dones, n_valid);
    check_val("b1_done_cyc", d_cyc, 7);
    check_val("b1_beats", n_beats, 4);
    check_val("b1_reads", n_reads, 4);
    check_val("b1_dones", n_dones, 1);

    run_burst(10'h010, 11'd4, 1, -1, 1'b0, d_cyc, n_beats, n_reads, n_dones, n_valid);
    check_val("b2_done_cyc", d_cyc, 13);
    check_val("b2_beats", n_beats, 4);
    check_val("b2_reads", n_reads, 4);
    check_val("b2_dones", n_dones, 1);

    run_burst(10'h3FE, 11'd4, 0, -1, 1'b0, d_cyc, n_beats, n_reads, n_dones, n_valid);
    check_val("b3_done_cyc", d_cyc, 7);
    check_val("b3_beats", n_beats, 4);
    check_val("b3_reads", n_reads, 4);

    run_burst(10'h123, 11'd0, 0, -1, 1'b0, d_cyc, n_beats, n_reads, n_dones, n_valid);
    check_val("z_done_cyc", d_cyc, 1);
    check_val("z_reads", n_reads, 0);
    check_val("z_valid", n_valid, 0);
    check_val("z_dones", n_dones, 1);

    run_burst(10'h000, 11'd1024, 2, 100, 1'b0, d_cyc, n_beats, n_reads, n_dones, n_valid);
    check_val("full_beats", n_beats, 1024);
    check_val("full_reads", n_reads, 1024);
    check_val("full_dones", n_dones, 1);
    check_val("full_finished", d_cyc >= 0, 1);

    // reset asserted during cycle 5 of an 8-word burst
    iBaseAddr = 10'h020; iCount = 11'd8; iReady = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      iStart = (c == 0);
      Reset  = (c == 5);
      @(negedge Clock);
      @(posedge Clock); #1;
    end
    Reset = 1'b0; iStart = 1'b0;
    @(negedge Clock);
    check_val("ra_rv",   bus.oReadValid,   0);
    check_val("ra_addr", bus.oReadAddress, 0);
    check_val("ra_data", bus.oData,        0);
    check_val("ra_ov",   bus.oValid,       0);
    check_val("ra_busy", oBusy,            0);
    check_val("ra_done", oDone,            0);
    idle_bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (bus.oValid || oDone || bus.oReadValid || oBusy) idle_bad++;
    end
    check_val("ra_quiet", idle_bad, 0);
    @(posedge Clock); #1;

    run_burst(10'h100, 11'd3, 0, -1, 1'b0, d_cyc, n_beats, n_reads, n_dones, n_valid);
    check_val("ra2_done_cyc", d_cyc, 6);
    check_val("ra2_beats", n_beats, 3);
    check_val("ra2_reads", n_reads, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side master for the single-read-port RAM block, which has a 1-cycle registered read latency. It is the reader for that writer.
- On a start command it walks `iCount` consecutive addresses from `iBaseAddr` and streams the returned words out on a valid/ready interface.
- Full backpressure support via a 2-entry output buffer with credit-based issue; 1 word/cycle sustained throughput when the sink is always ready.
- Sits between RAM instances and downstream consumers (e.g. pixel/vertex fetch paths).

Parameters:
- `DATA_WIDTH`, 8, width of RAM words and stream data.
- `ADDR_WIDTH`, 10, RAM address width; address arithmetic wraps modulo 2^`ADDR_WIDTH`.

Ports:
- `Clock`  in  1  single clock, all logic on posedge.
- `Reset`  in  1  synchronous, active-high reset.
- `iStart`  in  1  start request; sampled only in IDLE.
- `iBaseAddr`  in  `ADDR_WIDTH`  first address of the burst; latched on accepted start.
- `iCount`  in  `ADDR_WIDTH`+1  number of words to read; latched on accepted start; 0 is legal.
- `oReadAddress`  out  `ADDR_WIDTH`  address driven to the RAM `iReadAddress`.
- `oReadValid`  out  1  high in cycles where `oReadAddress` is a real issued read.
- `iRamData`  in  `DATA_WIDTH`  RAM `oDataOut`; valid one cycle after the matching issue cycle.
- `oData`  out  `DATA_WIDTH`  stream data (head of output buffer).
- `oValid`  out  1  stream valid.
- `iReady`  in  1  stream ready; a beat transfers when `oValid` && `iReady`.
- `oBusy`  out  1  high from the cycle after the accepted start until `oDone`.
- `oDone`  out  1  one-cycle pulse when the burst completes.

Behaviour:
- **Reset:**
  - state=IDLE; `oReadAddress`=0; `oReadValid`=0; `oData`=0; `oValid`=0; `oBusy`=0; `oDone`=0.
  - Issue counter, beat counter, buffer occupancy and in-flight flag are cleared.
  - A RAM response arriving the cycle after reset is discarded.
  - Reset mid-burst aborts the burst: no `oDone`, no further beats.
- **States:** IDLE, RUN, DRAIN.
  - IDLE: `iStart`=1 latches base/count. With count>0 go to RUN; with count=0 go directly to a done pulse next cycle (`oDone`=1, `oBusy`=0, no reads, no beats).
  - RUN: issue reads while issued<count. Go to DRAIN when the last address has been issued.
  - DRAIN: wait until all `count` beats have transferred, then go to IDLE and assert `oDone` for 1 cycle. `oBusy` deasserts in the same cycle.
- `iStart` while not IDLE is ignored; no queuing.
- **Issue rule:** in RUN, issue in a cycle iff (occupancy + inflight − pop) < 2.
  - inflight = a read was issued the previous cycle.
  - pop = `oValid` && `iReady` this cycle.
  - Issued read k uses address (base + k) mod 2^`ADDR_WIDTH`; `oReadValid`=1 in that cycle.
  - In non-issue cycles `oReadAddress` holds its last value and `oReadValid`=0.
- **Response capture:** in the cycle after an issue, `iRamData` is written into the buffer tail at the clock edge. The buffer can never overflow (guaranteed by the issue rule). Word order is preserved.
- **Output:** `oValid`=1 iff occupancy>0; `oData` = buffer head, registered (no combinational path from `iRamData` or `iReady` to `oData`/`oValid`).
  - Simultaneous push and pop: occupancy unchanged.
  - `oData` holds stable while `oValid`=1 and `iReady`=0.
- **Latency:** start sampled at cycle 0 → first address at cycle 1 → first `oValid` at cycle 3.
  - With `iReady` held high: N beats on cycles 3..N+2, `oDone` at cycle N+3.
- **Counts:** `iCount` maximum is 2^`ADDR_WIDTH`, so the full RAM is read exactly once. Counters are `ADDR_WIDTH`+1 bits wide.
- **RAM write-through:** handled entirely inside the RAM; this block is unaware of it.

Test Plan:
- Base=0x010, count=4, `iReady`=1, RAM preloaded mem[a]=a[7:0] → addresses 0x010..0x013 on cycles 1–4; beats 0x10,0x11,0x12,0x13 on cycles 3–6; `oDone`=1 on cycle 7 only; `oBusy` high cycles 1–6.
- Same burst with `iReady` low on cycles 3–8 → at most 2 buffered words plus 0 in flight; `oReadValid` stalls; `oData`=0x10 stable throughout; all 4 beats delivered in order after `iReady` rises, none lost or duplicated.
- Base=0x3FE, count=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001; data in the same order.
- Count=0 → `oDone` on cycle 1, `oReadValid` never asserted, `oValid` never asserted.
- Random `iReady` (50%), count=1024 → 1024 beats matching mem[0..1023] in order; exactly one `oDone`. A second `iStart` pulsed mid-burst has no effect.
- `Reset` asserted at cycle 5 of a count=8 burst → next cycle all outputs are at reset values, no `oDone`; a new start then runs a clean burst from its own base.
